// File: rtl/pipes_pkg.sv
// Shared execute-stage types: machine word, decoded op, divider FSM states and
// iteration counts, plus small op-classification helpers used by the divider.
package pipes;

  typedef logic [63:0] word_t;

  typedef enum logic [4:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU,
    OP_DIVW,
    OP_DIVUW,
    OP_REMW,
    OP_REMUW
  } decoded_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  localparam int DIV_ITER_64 = 64;
  localparam int DIV_ITER_32 = 32;

  function automatic logic is_div_op(input decoded_op_t op);
    case (op)
      OP_DIV, OP_DIVU, OP_REM, OP_REMU,
      OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input decoded_op_t op);
    case (op)
      OP_DIV, OP_REM, OP_DIVW, OP_REMW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_word_op(input decoded_op_t op);
    case (op)
      OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_rem_op(input decoded_op_t op);
    case (op)
      OP_REM, OP_REMU, OP_REMW, OP_REMUW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic word_t sext_word(input word_t x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider datapath: one quotient bit per step.
// Exposes the next-step quotient/remainder so the caller can capture the final step.
module div_core
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        clear,
  input  word_t       dividend,
  input  word_t       divisor,
  output logic [5:0]  count,
  output word_t       quo_next,
  output word_t       rem_next
);

  word_t       rem_q;
  word_t       quo_q;
  word_t       dvsr_q;
  logic [64:0] shifted;
  logic [64:0] diff;
  logic        qbit;

  // Trial subtraction; a borrow out of bit 64 means the divisor did not fit.
  always_comb begin
    shifted  = {rem_q, quo_q[63]};
    diff     = shifted - {1'b0, dvsr_q};
    qbit     = ~diff[64];
    rem_next = qbit ? diff[63:0] : shifted[63:0];
    quo_next = {quo_q[62:0], qbit};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      count  <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvsr_q <= divisor;
      count  <= '0;
    end else if (step) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      count <= count + 6'd1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV64M divider: FSM, operand sign handling, divide-by-zero and
// overflow shortcuts, and result selection around the unsigned div_core.
module div_unit
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  decoded_op_t op_i,
  input  word_t       a_i,
  input  word_t       b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output word_t       result_o
);

  div_state_t  state, state_next;
  decoded_op_t op_q;
  logic        q_neg_q;
  logic        r_neg_q;
  word_t       result_q;

  logic        accept, w_op, s_op, sa, sb, b_zero, ovf, special, last;
  word_t       a_ext, b_ext, a_mag, b_mag, special_res;
  word_t       core_dividend, core_divisor;
  word_t       quo_next, rem_next, q_fin, r_fin, run_res;
  logic [5:0]  count;

  // Operand preparation for the op presented in IDLE; W ops divide 32-bit values
  // left-aligned in the dividend so only 32 iterations are needed.
  always_comb begin
    accept  = (state == IDLE) & valid_i & is_div_op(op_i) & ~flush_i & ~reset;
    w_op    = is_word_op(op_i);
    s_op    = is_signed_op(op_i);
    a_ext   = w_op ? (s_op ? sext_word(a_i) : {32'h0, a_i[31:0]}) : a_i;
    b_ext   = w_op ? (s_op ? sext_word(b_i) : {32'h0, b_i[31:0]}) : b_i;
    sa      = s_op & a_ext[63];
    sb      = s_op & b_ext[63];
    a_mag   = sa ? -a_ext : a_ext;
    b_mag   = sb ? -b_ext : b_ext;
    b_zero  = (b_ext == '0);
    ovf     = s_op & (a_ext == (w_op ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))
                   & (b_ext == '1);
    special = b_zero | ovf;
    if (is_rem_op(op_i))
      special_res = b_zero ? a_ext : '0;
    else
      special_res = b_zero ? '1 : a_ext;
    if (w_op)
      special_res = sext_word(special_res);
    core_dividend = w_op ? {a_mag[31:0], 32'h0} : a_mag;
    core_divisor  = w_op ? {32'h0, b_mag[31:0]} : b_mag;
  end

  always_comb begin
    last    = (count == (is_word_op(op_q) ? 6'(DIV_ITER_32 - 1) : 6'(DIV_ITER_64 - 1)));
    q_fin   = q_neg_q ? -quo_next : quo_next;
    r_fin   = r_neg_q ? -rem_next : rem_next;
    run_res = is_rem_op(op_q) ? r_fin : q_fin;
    if (is_word_op(op_q))
      run_res = sext_word(run_res);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : RUN;
      RUN: begin
        if (flush_i)   state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The result register only changes on a completion, so it holds between ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_NOP;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= op_i;
      q_neg_q <= sa ^ sb;
      r_neg_q <= sa;
      if (special)
        result_q <= special_res;
    end else if ((state == RUN) && !flush_i && last) begin
      result_q <= run_res;
    end
  end

  div_core u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (accept & ~special),
    .step     ((state == RUN) & ~flush_i),
    .clear    (flush_i),
    .dividend (core_dividend),
    .divisor  (core_divisor),
    .count    (count),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  assign busy_o   = accept | ((state == RUN) & ~flush_i);
  assign done_o   = (state == DONE) & ~flush_i;
  assign result_o = result_q;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative multi-cycle integer divider for the execute stage of the RV64 pipeline. It consumes the decode-stage operand pair (srca/srcb after forwarding) plus the decoded op, and produces quotient or remainder for DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW. While an operation is in flight it raises a combinational busy so the pipeline stalls. Results follow RISC-V M-extension semantics, including divide-by-zero and signed-overflow cases.

## Interface
- No parameters; iteration counts are package constants.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  a division op is present in the stage; held stable with operands until done_o
- op_i  in  decoded_op_t  one of the eight division ops; any other value with valid_i=1 is ignored
- a_i  in  64  dividend (word_t)
- b_i  in  64  divisor (word_t)
- flush_i  in  1  abort the in-flight operation
- busy_o  out  1  stall request to the pipeline
- done_o  out  1  single-cycle pulse; result_o valid this cycle
- result_o  out  64  quotient or remainder, sign-extended from bit 31 for W ops

## Operation
- States: IDLE, RUN, DONE (div_state_t).
- IDLE: on valid_i with a division op and no flush_i, latch the op, |a| and |b| magnitudes (signed ops only), the sign of the quotient (sa^sb) and the sign of the remainder (sa). W ops use a_i[31:0] and b_i[31:0]; signed W ops sign-interpret bit 31.
- Special cases, detected at acceptance, go IDLE->DONE with result precomputed:
  - b==0: quotient = all ones; remainder = a (W: sign-extended a[31:0]).
  - Signed overflow (a = most negative, b = -1; 64-bit or 32-bit as appropriate): quotient = a; remainder = 0.
- Otherwise IDLE->RUN with count=0. RUN performs one restoring step per cycle on a 65-bit partial remainder and 64-bit quotient shift register. It uses N=DIV_ITER_64 (64) or DIV_ITER_32 (32; operands left-aligned so the low 32 bits are processed).
- When count==N-1, go to DONE. The registered result is computed on that transition: apply the sign fix-up (negate quotient if sign set, negate remainder if sa), select quotient or remainder by op, and for W ops sign-extend bit 31.
- DONE: done_o=1 for exactly one cycle, then IDLE unconditionally. valid_i is not re-sampled in DONE.
- busy_o = (IDLE & valid_i & div op & ~flush_i) | RUN. busy_o is 0 in DONE, so the stage advances in the done cycle.
- flush_i in any state: return to IDLE next cycle with no done_o. busy_o is 0 while flush_i=1.
- result_o holds its last value until the next completion.

## Timing
- Reset: state=IDLE, count=0, busy_o=0 (valid_i low), done_o=0, result_o=0, internal registers 0.
- Reset asserted mid-RUN: immediately IDLE, no done_o.
- Acceptance in cycle t, with done_o in cycle:
  - special case: t+1
  - normal W op: t+33
  - normal 64-bit op: t+65
- Throughput: one op per (latency+1) cycles. The cycle after DONE is IDLE and may accept a new op.
- flush_i and the final iteration in the same cycle: flush wins, no done_o.

## Structure
- pipes package: div_state_t; DIV_ITER_64 and DIV_ITER_32 constants.
- Reuse existing word_t and decoded_op_t.
- One sub-module, div_core: unsigned restoring iteration datapath (remainder/quotient registers, counter). div_unit keeps the FSM, sign handling, special cases and result select.

## Test plan
- DIVU a=100, b=7 -> done_o at t+65, result_o=14. REMU with the same operands -> 2.
- DIV a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIV a=5, b=0 -> done_o at t+1, result 0xFFFF_FFFF_FFFF_FFFF. REMU a=5, b=0 -> 5.
- DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000. DIVW a=0x1_8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000 at t+1. REMW with the same operands -> 0.
- REMUW a=0x1_0000_0005, b=3 -> 2 at t+33. DIVW a=-9, b=4 -> 0xFFFF_FFFF_FFFF_FFFE.
- flush_i at RUN iteration 10 -> IDLE next cycle, busy_o=0, no done_o; a following DIVU 9/3 -> 3. Reset asserted mid-RUN -> all outputs 0 immediately.
